// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - async FIFO write-domain pointer, full/almost-full, level and overflow control
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rq2_rptr_gray,
  input  logic                  clr_overflow,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  mem_we,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AFULL_T = PW'(AFULL_THRESH);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin_sync;
  logic [PW-1:0] level_next;
  logic [PW-1:0] full_match;
  logic          accept;

  assign accept     = wr_en & ~full;
  assign mem_we     = accept;
  assign waddr      = wbin[ADDR_WIDTH-1:0];
  assign wbin_next  = wbin + {{ADDR_WIDTH{1'b0}}, accept};
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits from the MSB down to it
  for (genvar i = 0; i < PW; i++) begin : g_g2b
    assign rbin_sync[i] = ^(rq2_rptr_gray >> i);
  end

  assign level_next = wbin_next - rbin_sync;
  assign full_match = {~rq2_rptr_gray[ADDR_WIDTH:ADDR_WIDTH-1], rq2_rptr_gray[ADDR_WIDTH-2:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin        <= '0;
      wr_ptr_gray <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      overflow    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wr_ptr_gray <= wgray_next;
      full        <= (wgray_next == full_match);
      almost_full <= (level_next >= AFULL_T);
      wr_level    <= level_next;
      // set has priority over clear
      overflow    <= (overflow & ~clr_overflow) | (wr_en & full);
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb/tb_fifo_wr_ctrl.sv - directed self-checking bench for fifo_wr_ctrl
module tb_fifo_wr_ctrl;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [4:0] rq2_rptr_gray;
  logic       clr_overflow;
  logic [4:0] wr_ptr_gray;
  logic [3:0] waddr;
  logic       mem_we;
  logic       full;
  logic       almost_full;
  logic [4:0] wr_level;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  fifo_wr_ctrl #(.ADDR_WIDTH(4), .AFULL_THRESH(14)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .rq2_rptr_gray(rq2_rptr_gray),
    .clr_overflow(clr_overflow),
    .wr_ptr_gray(wr_ptr_gray),
    .waddr(waddr),
    .mem_we(mem_we),
    .full(full),
    .almost_full(almost_full),
    .wr_level(wr_level),
    .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [4:0] g(input logic [4:0] x);
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " gray"},  32'(wr_ptr_gray), 0);
    chk({tag, " waddr"}, 32'(waddr), 0);
    chk({tag, " we"},    32'(mem_we), 0);
    chk({tag, " full"},  32'(full), 0);
    chk({tag, " af"},    32'(almost_full), 0);
    chk({tag, " level"}, 32'(wr_level), 0);
    chk({tag, " ovf"},   32'(overflow), 0);
  endtask

  initial begin
    int w;
    rst_n = 1'b0;
    wr_en = 1'b0;
    rq2_rptr_gray = 5'd0;
    clr_overflow = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;

    // fill 16 entries with read pointer at 0
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      #1;
      chk("fill waddr", 32'(waddr), 32'(i));
      chk("fill we", 32'(mem_we), 1);
      tick();
      chk("fill level", 32'(wr_level), 32'(i + 1));
      chk("fill af", 32'(almost_full), (i >= 13) ? 1 : 0);
      chk("fill full", 32'(full), (i == 15) ? 1 : 0);
    end
    chk("fill gray", 32'(wr_ptr_gray), 32'h18);

    // writes while full
    #1;
    chk("ovf we0", 32'(mem_we), 0);
    tick();
    chk("ovf set", 32'(overflow), 1);
    chk("ovf gray", 32'(wr_ptr_gray), 32'h18);
    chk("ovf we1", 32'(mem_we), 0);
    tick();
    chk("ovf gray2", 32'(wr_ptr_gray), 32'h18);
    chk("ovf lvl", 32'(wr_level), 16);
    wr_en = 1'b0;
    clr_overflow = 1'b1;
    tick();
    chk("ovf clr", 32'(overflow), 0);
    wr_en = 1'b1;
    tick();
    chk("ovf set wins", 32'(overflow), 1);
    wr_en = 1'b0;
    clr_overflow = 1'b0;
    tick();
    chk("ovf sticky", 32'(overflow), 1);

    // one read observed, then refill
    rq2_rptr_gray = 5'b00001;
    tick();
    chk("rd full", 32'(full), 0);
    chk("rd level", 32'(wr_level), 15);
    chk("rd af", 32'(almost_full), 1);
    wr_en = 1'b1;
    #1;
    chk("refill we", 32'(mem_we), 1);
    chk("refill waddr", 32'(waddr), 0);
    tick();
    wr_en = 1'b0;
    chk("refill full", 32'(full), 1);
    chk("refill gray", 32'(wr_ptr_gray), 32'h19);
    chk("refill level", 32'(wr_level), 16);
    chk("refill ovf", 32'(overflow), 1);

    // asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    rq2_rptr_gray = 5'd0;
    #1;
    chk_all_zero("async rst");
    tick();
    rst_n = 1'b1;
    wr_en = 1'b1;
    #1;
    chk("post rst waddr", 32'(waddr), 0);
    chk("post rst we", 32'(mem_we), 1);
    tick();
    chk("post rst gray", 32'(wr_ptr_gray), 32'h01);
    chk("post rst level", 32'(wr_level), 1);

    // wrap-around with read pointer trailing by two
    tick();
    chk("wrap pre level", 32'(wr_level), 2);
    w = 2;
    for (int k = 0; k < 34; k++) begin
      rq2_rptr_gray = g(5'((w + 31) % 32));
      wr_en = 1'b1;
      #1;
      chk("wrap waddr", 32'(waddr), 32'(w % 16));
      tick();
      w = (w + 1) % 32;
      chk("wrap gray", 32'(wr_ptr_gray), 32'(g(5'(w))));
      chk("wrap full", 32'(full), 0);
      chk("wrap level", 32'(wr_level), 2);
    end
    wr_en = 1'b0;

    // simultaneous write and read-pointer change
    #2;
    rst_n = 1'b0;
    rq2_rptr_gray = 5'd0;
    tick();
    rst_n = 1'b1;
    wr_en = 1'b1;
    for (int i = 0; i < 13; i++) tick();
    chk("sim13 level", 32'(wr_level), 13);
    chk("sim13 af", 32'(almost_full), 0);
    rq2_rptr_gray = 5'b00001;
    tick();
    wr_en = 1'b0;
    chk("sim level", 32'(wr_level), 13);
    chk("sim af", 32'(almost_full), 0);
    chk("sim gray", 32'(wr_ptr_gray), 32'(g(5'd14)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
